// File: rtl/wb_arbiter_2x1_rr_if.sv
// Wishbone B4 bus bundle shared by the 2:1 arbiter and its requesters/target.
// Signal names follow Wishbone, lower-cased.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            we;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, cti, bte, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cti, bte, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2x1_rr.sv
// Two-requester round-robin Wishbone arbiter with a stall watchdog.
// Ownership is held for the whole CYC so bursts are never split.
module wb_arbiter_2x1_rr #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    wb_if.slave        m0,
    wb_if.slave        m1,
    wb_if.master       s0,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    logic            last;
    logic [CW-1:0]   wd_cnt;

    logic [WB_ADDR_WIDTH-1:0] o_adr;
    logic [WB_DATA_WIDTH-1:0] o_dat_w;
    logic [SW-1:0]            o_sel;
    logic [2:0]               o_cti;
    logic [1:0]               o_bte;
    logic                     o_we;
    logic                     o_cyc;
    logic                     o_stb;
    logic                     stall;
    logic                     fire;

    always_comb begin
        o_adr   = '0;
        o_dat_w = '0;
        o_sel   = '0;
        o_cti   = '0;
        o_bte   = '0;
        o_we    = 1'b0;
        o_cyc   = 1'b0;
        o_stb   = 1'b0;
        unique case (state)
            OWN0: begin
                o_adr   = m0.adr;
                o_dat_w = m0.dat_w;
                o_sel   = m0.sel;
                o_cti   = m0.cti;
                o_bte   = m0.bte;
                o_we    = m0.we;
                o_cyc   = m0.cyc;
                o_stb   = m0.stb;
            end
            OWN1: begin
                o_adr   = m1.adr;
                o_dat_w = m1.dat_w;
                o_sel   = m1.sel;
                o_cti   = m1.cti;
                o_bte   = m1.bte;
                o_we    = m1.we;
                o_cyc   = m1.cyc;
                o_stb   = m1.stb;
            end
            default: ;
        endcase
    end

    // A slave response in the limit cycle wins over the forced error.
    assign stall = o_cyc & o_stb & ~s0.ack & ~s0.err;
    assign fire  = (TIMEOUT_CYCLES != 0) && stall && (wd_cnt == TO_LIM);

    assign s0.adr   = o_adr;
    assign s0.dat_w = o_dat_w;
    assign s0.sel   = o_sel;
    assign s0.cti   = o_cti;
    assign s0.bte   = o_bte;
    assign s0.we    = o_we;
    assign s0.cyc   = o_cyc;
    assign s0.stb   = o_stb & ~fire;

    assign grant       = {state == OWN1, state == OWN0};
    assign timeout_evt = fire;

    assign m0.ack   = grant[0] & s0.ack;
    assign m0.err   = grant[0] & (s0.err | fire);
    assign m1.ack   = grant[1] & s0.ack;
    assign m1.err   = grant[1] & (s0.err | fire);
    assign m0.dat_r = s0.dat_r;
    assign m1.dat_r = s0.dat_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            wd_cnt <= '0;
        end else begin
            // Owner dropping CYC also drops stall, so handover clears the count.
            if ((TIMEOUT_CYCLES != 0) && stall && !fire)
                wd_cnt <= wd_cnt + CW'(1);
            else
                wd_cnt <= '0;

            unique case (state)
                IDLE: begin
                    if (m0.cyc && (!m1.cyc || last))
                        state <= OWN0;
                    else if (m1.cyc)
                        state <= OWN1;
                end
                OWN0: begin
                    if (!m0.cyc) begin
                        last  <= 1'b0;
                        state <= m1.cyc ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (!m1.cyc) begin
                        last  <= 1'b1;
                        state <= m0.cyc ? OWN0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2x1_rr.sv
// Bench for wb_arbiter_2x1_rr: directed scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_wb_arbiter_2x1_rr;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       timeout_evt;

    wb_if #(.AW(AW), .DW(DW)) m0_bus ();
    wb_if #(.AW(AW), .DW(DW)) m1_bus ();
    wb_if #(.AW(AW), .DW(DW)) s0_bus ();

    always #5 clk = ~clk;

    wb_arbiter_2x1_rr #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .s0         (s0_bus),
        .grant      (grant),
        .timeout_evt(timeout_evt)
    );

    int n_checks = 0;
    int n_fails  = 0;

    bit          cyc [2];
    bit          stb [2];
    bit          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dw  [2];
    logic [SW-1:0] sel [2];
    logic [2:0]    cti [2];
    logic [1:0]    bte [2];
    bit            s_ack;
    bit            s_err;
    logic [DW-1:0] s_rd;

    // Model: who owns the bus (-1 none), who finished last, stall run length.
    int own;
    int last_m;
    int stalls;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    task automatic drive();
        m0_bus.cyc   = cyc[0];  m1_bus.cyc   = cyc[1];
        m0_bus.stb   = stb[0];  m1_bus.stb   = stb[1];
        m0_bus.we    = we[0];   m1_bus.we    = we[1];
        m0_bus.adr   = adr[0];  m1_bus.adr   = adr[1];
        m0_bus.dat_w = dw[0];   m1_bus.dat_w = dw[1];
        m0_bus.sel   = sel[0];  m1_bus.sel   = sel[1];
        m0_bus.cti   = cti[0];  m1_bus.cti   = cti[1];
        m0_bus.bte   = bte[0];  m1_bus.bte   = bte[1];
        s0_bus.ack   = s_ack;
        s0_bus.err   = s_err;
        s0_bus.dat_r = s_rd;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit busy;
        int o;
        bit fire;
        logic [11:0]   e_ctl;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dw;
        drive();
        #1;
        busy  = (own >= 0);
        o     = busy ? own : 0;
        fire  = busy && cyc[o] && stb[o] && !s_ack && !s_err && stalls == TO;
        e_ctl = '0;
        e_adr = '0;
        e_dw  = '0;
        if (busy) begin
            e_ctl = {cyc[o], stb[o] & ~fire, we[o], sel[o], cti[o], bte[o]};
            e_adr = adr[o];
            e_dw  = dw[o];
        end
        chk("grant", 64'(grant), busy ? (o == 0 ? 64'd1 : 64'd2) : 64'd0);
        chk("s0_ctl", 64'({s0_bus.cyc, s0_bus.stb, s0_bus.we, s0_bus.sel,
                           s0_bus.cti, s0_bus.bte}), 64'(e_ctl));
        chk("s0_adr", 64'(s0_bus.adr), 64'(e_adr));
        chk("s0_dat_w", 64'(s0_bus.dat_w), 64'(e_dw));
        chk("resp", 64'({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err,
                         timeout_evt}),
            64'({busy && o == 0 && s_ack, busy && o == 0 && (s_err || fire),
                 busy && o == 1 && s_ack, busy && o == 1 && (s_err || fire),
                 fire}));
        chk("dat_r", {m0_bus.dat_r, m1_bus.dat_r}, {s_rd, s_rd});
        @(posedge clk);
        if (rst) begin
            own    = -1;
            last_m = 1;
            stalls = 0;
        end else begin
            if (busy && cyc[o] && stb[o] && !s_ack && !s_err && !fire)
                stalls++;
            else
                stalls = 0;
            if (!busy) begin
                if (cyc[0] && cyc[1]) own = 1 - last_m;
                else if (cyc[0])      own = 0;
                else if (cyc[1])      own = 1;
            end else if (!cyc[o]) begin
                last_m = o;
                own    = cyc[1 - o] ? 1 - o : -1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int cur;
        bit quiet;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0;
            dw[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
        end
        s_ack = 0; s_err = 0; s_rd = '0;
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        own = -1; last_m = 1; stalls = 0;
        @(negedge clk);

        step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s0_cyc", 64'(s0_bus.cyc), 64'd0);
        chk("rst_evt", 64'(timeout_evt), 64'd0);
        rst = 1'b0;

        // Simultaneous first request: m0 wins the tie.
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h1000; we[0] = 1;
        sel[0] = 4'hf; dw[0] = 32'h1111_0000;
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h2000; sel[1] = 4'h3;
        s_rd = 32'hcafe_0001;
        step();
        chk("tie_grant", 64'(grant), 64'd1);
        chk("tie_adr", 64'(s0_bus.adr), 64'h1000);

        // Four-beat burst with m1 waiting.
        for (int b = 0; b < 4; b++) begin
            cti[0] = (b == 3) ? 3'b111 : 3'b010;
            adr[0] = 32'h1000 + 32'(b * 4);
            s_ack  = 1;
            drive();
            #1;
            chk("burst_m0_ack", 64'(m0_bus.ack), 64'd1);
            chk("burst_m1_ack", 64'(m1_bus.ack), 64'd0);
            step();
        end
        cyc[0] = 0; stb[0] = 0; cti[0] = '0; s_ack = 0;
        step();
        chk("handover_grant", 64'(grant), 64'd2);

        // Back-to-back single beats alternate ownership.
        cur = 1;
        cyc[0] = 1; stb[0] = 1;
        for (int k = 0; k < 4; k++) begin
            s_ack = 1;
            step();
            cyc[cur] = 0; stb[cur] = 0; s_ack = 0;
            step();
            chk("alt_grant", 64'(grant), cur == 1 ? 64'd1 : 64'd2);
            cyc[cur] = 1; stb[cur] = 1;
            cur = 1 - cur;
        end

        // m1 stalls against a silent slave until the watchdog fires.
        cyc[0] = 0; stb[0] = 0;
        repeat (TO) step();
        drive();
        #1;
        chk("wd_m1_err", 64'(m1_bus.err), 64'd1);
        chk("wd_evt", 64'(timeout_evt), 64'd1);
        chk("wd_s0_stb", 64'(s0_bus.stb), 64'd0);
        chk("wd_grant", 64'(grant), 64'd2);
        step();

        // Slave answers on the limit cycle: its ACK wins.
        repeat (TO) step();
        s_ack = 1;
        drive();
        #1;
        chk("race_m1_ack", 64'(m1_bus.ack), 64'd1);
        chk("race_m1_err", 64'(m1_bus.err), 64'd0);
        chk("race_evt", 64'(timeout_evt), 64'd0);
        step();
        s_ack = 0;

        // Reset lands in the middle of an m0 burst.
        cyc[1] = 0; stb[1] = 0;
        step();
        cyc[0] = 1; stb[0] = 1; cti[0] = 3'b010; s_ack = 1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_burst_grant", 64'(grant), 64'd0);
        chk("rst_burst_cyc", 64'(s0_bus.cyc), 64'd0);
        rst = 1'b0;
        cyc[0] = 0; stb[0] = 0; cti[0] = '0; s_ack = 0;
        cyc[1] = 1; stb[1] = 1;
        step();
        chk("post_rst_grant", 64'(grant), 64'd2);

        // Random traffic with quiet-slave stretches to reach the watchdog.
        quiet = 0;
        repeat (2000) begin
            for (int i = 0; i < 2; i++) begin
                if (!cyc[i]) cyc[i] = ($urandom % 3 == 0);
                else if ($urandom % 10 == 0) cyc[i] = 0;
                stb[i] = cyc[i] && ($urandom % 4 != 0);
                we[i]  = $urandom % 2;
                adr[i] = $urandom;
                dw[i]  = $urandom;
                sel[i] = SW'($urandom);
                cti[i] = 3'($urandom);
                bte[i] = 2'($urandom);
            end
            if ($urandom % 40 == 0) quiet = !quiet;
            s_ack = !quiet && ($urandom % 3 == 0);
            s_err = !quiet && ($urandom % 12 == 0);
            s_rd  = $urandom;
            rst   = ($urandom % 250 == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
